// File: rtl/i2c_pkg.sv
// Shared types for the I2C register-file controller.
package i2c_pkg;

  typedef enum logic {REG_ST_PTR, REG_ST_DATA} reg_state_t;

  typedef logic [7:0] byte_t;

  localparam int REG_PTR_MAX_W = 8;

endpackage

// File: rtl/i2c_reg_timeout.sv
// Saturating idle counter: clear restarts it, expire holds once LIMIT-1 cycles of inactivity are reached.
module i2c_reg_timeout #(
  parameter int LIMIT = 2000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic expire
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/i2c_reg_ctrl.sv
// Pointer-addressed 8-bit register bank behind i2c_slave (first written byte = pointer, then auto-increment data).
// Defining I2C_REG_CTRL_WRITE_IRQ_EN adds the wr_irq_o / wr_addr_o write-notify outputs.
module i2c_reg_ctrl
  import i2c_pkg::*;
#(
  parameter int                  NUM_REGS     = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK      = '0,
  parameter int                  IDLE_TIMEOUT = 2000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    data_o,
  input  logic                          data_o_valid,
  output logic [7:0]                    data_i,
  output logic                          data_i_valid,
  input  logic                          data_i_ready,
  input  logic [NUM_REGS*8-1:0]         hw_status_i,
  output logic [NUM_REGS*8-1:0]         regs_o,
  output logic [$clog2(NUM_REGS)-1:0]   ptr_o,
`ifdef I2C_REG_CTRL_WRITE_IRQ_EN
  output logic                          wr_irq_o,
  output logic [$clog2(NUM_REGS)-1:0]   wr_addr_o,
`endif
  output logic                          coll_err_o
);

  localparam int AW = $clog2(NUM_REGS);

  reg_state_t    state, state_next, eff_state;
  logic [AW-1:0] ptr;
  byte_t         regs     [NUM_REGS];
  byte_t         hw_bytes [NUM_REGS];
  byte_t         read_byte;
  logic          expire;
  logic          ptr_load, data_wr, wr_en, read_stb, ptr_inc;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_slots
    assign hw_bytes[i]       = hw_status_i[i*8 +: 8];
    assign regs_o[i*8 +: 8]  = RO_MASK[i] ? 8'h00 : regs[i];
  end

  i2c_reg_timeout #(
    .LIMIT (IDLE_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (data_o_valid | data_i_ready),
    .expire (expire)
  );

  // An expired idle window ends the transaction even in the cycle it fires, so that byte is a pointer.
  assign eff_state = expire ? REG_ST_PTR : state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= REG_ST_PTR;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = eff_state;
    if (data_o_valid && eff_state == REG_ST_PTR) begin
      state_next = REG_ST_DATA;
    end
  end

  always_comb begin
    ptr_load = 1'b0;
    data_wr  = 1'b0;
    case (eff_state)
      REG_ST_PTR:  ptr_load = data_o_valid;
      REG_ST_DATA: data_wr  = data_o_valid;
      default:     ;
    endcase
    wr_en    = data_wr && !RO_MASK[ptr];
    read_stb = data_i_ready && !data_o_valid;
    ptr_inc  = data_wr || read_stb;
  end

  assign read_byte = RO_MASK[ptr] ? hw_bytes[ptr] : regs[ptr];

  // Any pointer movement drops data_i_valid for one cycle so data_i never shows a stale slot while valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      ptr          <= '0;
      data_i       <= '0;
      data_i_valid <= 1'b0;
      coll_err_o   <= 1'b0;
    end else begin
      if (wr_en) begin
        regs[ptr] <= data_o;
      end
      if (ptr_load) begin
        ptr <= data_o[AW-1:0];
      end else if (ptr_inc) begin
        ptr <= ptr + 1'b1;
      end
      data_i       <= read_byte;
      data_i_valid <= !(data_o_valid || data_i_ready);
      if (data_o_valid && data_i_ready) begin
        coll_err_o <= 1'b1;
      end
    end
  end

  assign ptr_o = ptr;

`ifdef I2C_REG_CTRL_WRITE_IRQ_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_irq_o  <= 1'b0;
      wr_addr_o <= '0;
    end else begin
      wr_irq_o <= wr_en;
      if (wr_en) begin
        wr_addr_o <= ptr;
      end
    end
  end
`endif

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed self-checking bench for i2c_reg_ctrl driving the slave-side byte handshake directly.
module tb_i2c_reg_ctrl;

  localparam int NUM_REGS = 16;
  localparam int IDLE     = 2000;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [7:0]            data_o;
  logic                  data_o_valid;
  logic [7:0]            data_i;
  logic                  data_i_valid;
  logic                  data_i_ready;
  logic [NUM_REGS*8-1:0] hw_status_i;
  logic [NUM_REGS*8-1:0] regs_o;
  logic [3:0]            ptr_o;
  logic                  coll_err_o;
`ifdef I2C_REG_CTRL_WRITE_IRQ_EN
  logic                  wr_irq_o;
  logic [3:0]            wr_addr_o;
`endif

  int total = 0;
  int bad   = 0;

  i2c_reg_ctrl #(
    .NUM_REGS     (NUM_REGS),
    .RO_MASK      (16'h8000),
    .IDLE_TIMEOUT (IDLE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_o       (data_o),
    .data_o_valid (data_o_valid),
    .data_i       (data_i),
    .data_i_valid (data_i_valid),
    .data_i_ready (data_i_ready),
    .hw_status_i  (hw_status_i),
    .regs_o       (regs_o),
    .ptr_o        (ptr_o),
`ifdef I2C_REG_CTRL_WRITE_IRQ_EN
    .wr_irq_o     (wr_irq_o),
    .wr_addr_o    (wr_addr_o),
`endif
    .coll_err_o   (coll_err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    data_o       = b;
    data_o_valid = 1'b1;
    tick();
    data_o_valid = 1'b0;
    tick();
  endtask

  // Handshake only; callers judge the returned flags and byte.
  task automatic read_byte(output logic [7:0] b, output logic seen, output logic dropped);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (data_i_valid === 1'b1) seen = 1'b1;
      else tick();
    end
    b            = data_i;
    data_i_ready = 1'b1;
    tick();
    data_i_ready = 1'b0;
    dropped      = (data_i_valid === 1'b0);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_gap(2);
    total++;
    if (regs_o !== '0) begin bad++; $display("[TB] FAIL reset_regs: got %h expected 0", regs_o); end
    total++;
    if (ptr_o !== 4'd0) begin bad++; $display("[TB] FAIL reset_ptr: got %0d expected 0", ptr_o); end
    total++;
    if (data_i_valid !== 1'b0 || data_i !== 8'h00) begin
      bad++; $display("[TB] FAIL reset_read: got valid=%b data=%h expected valid=0 data=00", data_i_valid, data_i);
    end
    total++;
    if (coll_err_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_coll: got %b expected 0", coll_err_o); end
    rst_n = 1'b1;
    total++;
    if (data_i_valid !== 1'b0) begin bad++; $display("[TB] FAIL release_valid_low: got %b expected 0", data_i_valid); end
    tick();
    total++;
    if (data_i_valid !== 1'b1 || data_i !== 8'h00) begin
      bad++; $display("[TB] FAIL release_valid_high: got valid=%b data=%h expected valid=1 data=00", data_i_valid, data_i);
    end
  endtask

  task automatic test_write();
    logic [NUM_REGS*8-1:0] exp_regs;
    send_byte(8'h03);
    send_byte(8'h5A);
    send_byte(8'h33);
    exp_regs          = '0;
    exp_regs[3*8 +: 8] = 8'h5A;
    exp_regs[4*8 +: 8] = 8'h33;
    total++;
    if (regs_o !== exp_regs) begin bad++; $display("[TB] FAIL write_regs: got %h expected %h", regs_o, exp_regs); end
    total++;
    if (ptr_o !== 4'd5) begin bad++; $display("[TB] FAIL write_ptr: got %0d expected 5", ptr_o); end
  endtask

  task automatic test_read();
    logic [7:0] b;
    logic seen, dropped;
    idle_gap(IDLE + 10);
    send_byte(8'h03);
    read_byte(b, seen, dropped);
    total++;
    if (!seen || b !== 8'h5A) begin bad++; $display("[TB] FAIL read0: got seen=%b byte=%h expected seen=1 byte=5a", seen, b); end
    total++;
    if (!dropped) begin bad++; $display("[TB] FAIL read0_gap: got valid=1 after ready expected valid=0"); end
    read_byte(b, seen, dropped);
    total++;
    if (!seen || b !== 8'h33) begin bad++; $display("[TB] FAIL read1: got seen=%b byte=%h expected seen=1 byte=33", seen, b); end
    total++;
    if (ptr_o !== 4'd5) begin bad++; $display("[TB] FAIL read_ptr: got %0d expected 5", ptr_o); end
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    logic seen, dropped;
    idle_gap(IDLE + 10);
    send_byte(8'h0E);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    total++;
    if (regs_o[14*8 +: 8] !== 8'h11 || regs_o[15*8 +: 8] !== 8'h00 || regs_o[0 +: 8] !== 8'h33) begin
      bad++; $display("[TB] FAIL wrap_regs: got r14=%h r15=%h r0=%h expected 11 00 33",
                      regs_o[14*8 +: 8], regs_o[15*8 +: 8], regs_o[0 +: 8]);
    end
    total++;
    if (ptr_o !== 4'd1) begin bad++; $display("[TB] FAIL wrap_ptr: got %0d expected 1", ptr_o); end
    idle_gap(IDLE + 10);
    send_byte(8'h0F);
    read_byte(b, seen, dropped);
    total++;
    if (!seen || b !== 8'hA7) begin bad++; $display("[TB] FAIL ro_read: got seen=%b byte=%h expected seen=1 byte=a7", seen, b); end
    read_byte(b, seen, dropped);
    total++;
    if (!seen || b !== 8'h33) begin bad++; $display("[TB] FAIL wrap_read: got seen=%b byte=%h expected seen=1 byte=33", seen, b); end
  endtask

  task automatic test_timeout();
    idle_gap(IDLE + 10);
    send_byte(8'h05);
    send_byte(8'hC4);
    idle_gap(IDLE - 100);
    send_byte(8'h5B);
    idle_gap(IDLE + 10);
    send_byte(8'h07);
    send_byte(8'hFF);
    total++;
    if (regs_o[5*8 +: 8] !== 8'hC4 || regs_o[6*8 +: 8] !== 8'h5B || regs_o[7*8 +: 8] !== 8'hFF) begin
      bad++; $display("[TB] FAIL timeout_regs: got r5=%h r6=%h r7=%h expected c4 5b ff",
                      regs_o[5*8 +: 8], regs_o[6*8 +: 8], regs_o[7*8 +: 8]);
    end
    total++;
    if (ptr_o !== 4'd8) begin bad++; $display("[TB] FAIL timeout_ptr: got %0d expected 8", ptr_o); end
  endtask

  task automatic test_collision();
    idle_gap(IDLE + 10);
    send_byte(8'h0A);
    data_o       = 8'h77;
    data_o_valid = 1'b1;
    data_i_ready = 1'b1;
    tick();
    data_o_valid = 1'b0;
    data_i_ready = 1'b0;
    tick();
    total++;
    if (coll_err_o !== 1'b1) begin bad++; $display("[TB] FAIL coll_flag: got %b expected 1", coll_err_o); end
    total++;
    if (ptr_o !== 4'd11 || regs_o[10*8 +: 8] !== 8'h77) begin
      bad++; $display("[TB] FAIL coll_write: got ptr=%0d r10=%h expected ptr=11 r10=77", ptr_o, regs_o[10*8 +: 8]);
    end
    data_o       = 8'h55;
    data_o_valid = 1'b1;
    rst_n        = 1'b0;
    tick();
    data_o_valid = 1'b0;
    tick();
    total++;
    if (regs_o !== '0 || ptr_o !== 4'd0 || coll_err_o !== 1'b0 || data_i_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL midreset: got regs=%h ptr=%0d coll=%b valid=%b expected all 0",
                      regs_o, ptr_o, coll_err_o, data_i_valid);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (data_i_valid !== 1'b1 || data_i !== 8'h00) begin
      bad++; $display("[TB] FAIL midreset_release: got valid=%b data=%h expected valid=1 data=00", data_i_valid, data_i);
    end
  endtask

`ifdef I2C_REG_CTRL_WRITE_IRQ_EN
  task automatic test_irq();
    send_byte(8'h02);
    total++;
    if (wr_irq_o !== 1'b0) begin bad++; $display("[TB] FAIL irq_ptr_byte: got %b expected 0", wr_irq_o); end
    data_o       = 8'h99;
    data_o_valid = 1'b1;
    tick();
    data_o_valid = 1'b0;
    total++;
    if (wr_irq_o !== 1'b1 || wr_addr_o !== 4'd2) begin
      bad++; $display("[TB] FAIL irq_pulse: got irq=%b addr=%0d expected irq=1 addr=2", wr_irq_o, wr_addr_o);
    end
    tick();
    total++;
    if (wr_irq_o !== 1'b0) begin bad++; $display("[TB] FAIL irq_width: got %b expected 0", wr_irq_o); end
    idle_gap(IDLE + 10);
    send_byte(8'h0F);
    data_o       = 8'h12;
    data_o_valid = 1'b1;
    tick();
    data_o_valid = 1'b0;
    total++;
    if (wr_irq_o !== 1'b0) begin bad++; $display("[TB] FAIL irq_ro_write: got %b expected 0", wr_irq_o); end
  endtask
`endif

  initial begin
    rst_n        = 1'b0;
    data_o       = 8'h00;
    data_o_valid = 1'b0;
    data_i_ready = 1'b0;
    hw_status_i  = {8'hA7, {15{8'hEE}}};
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_timeout();
    test_collision();
`ifdef I2C_REG_CTRL_WRITE_IRQ_EN
    test_irq();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
